itype_instr_gen: RTL and testbench
==================================

Name: itype_instr_gen

Overview:
Instruction generator that feeds the I-type core's `instruction` input. It is the encoder counterpart of the core's decoder. It accepts symbolic operations (op, rd, rs1, imm) over a valid/ready handshake and encodes each one into a 32-bit RV32I OP-IMM word. Words are buffered in a small FIFO and issued to the core with programmable spacing; a canonical NOP is driven whenever no instruction is being issued.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
GAP, 1, NOP cycles inserted after each issued instruction (0 = back-to-back)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
in_valid  input  1  op fields valid
in_ready  output  1  generator can accept (FIFO not full)
in_op  input  4  operation select: 0 ADDI, 1 SLTI, 2 SLTIU, 3 XORI, 4 ORI, 5 ANDI, 6 SLLI, 7 SRLI, 8 SRAI; 9-15 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register
in_imm  input  12  immediate; for shifts only [4:0] (shamt) is used
hold  input  1  core stall; freezes issue
instruction  output  32  word to core (drive to core's instruction port)
issue_valid  output  1  instruction holds a real (non-NOP) word this cycle
err_illegal  output  1  one-cycle pulse when a handshake carries an illegal op
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst==0 at a clock edge): FIFO flushed. instruction=32'h0000_0013 (addi x0,x0,0). issue_valid=0, err_illegal=0, fifo_count=0, FSM=IDLE. in_ready=0 while rst is low. Reset mid-operation discards all queued and in-flight words.
- Encoding (combinational, before the FIFO write): opcode[6:0]=7'b0010011, rd→[11:7], rs1→[19:15].
- funct3[14:12]: ADDI 000, SLTI 010, SLTIU 011, XORI 100, ORI 110, ANDI 111, SLLI 001, SRLI 101, SRAI 101.
- Immediate [31:20]: non-shift ops use in_imm verbatim. Shifts use {funct7, in_imm[4:0]}, with funct7=7'b0000000 (SLLI/SRLI) or 7'b0100000 (SRAI); in_imm[11:5] is ignored.
- Handshake: in_ready = (fifo_count < DEPTH). Accept when in_valid && in_ready; the word is written at that edge.
- No push/pop bypass when full: in_ready is computed from registered count only.
- Illegal op: the handshake still completes but no entry is written. err_illegal=1 on the next cycle for exactly one cycle.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- FSM (registered outputs):
  - IDLE: if count≠0 && !hold, pop; next cycle instruction=word, issue_valid=1, go ISSUE. Else instruction=NOP, issue_valid=0.
  - ISSUE (1 cycle): if GAP==0 && count≠0 && !hold, pop the next word back-to-back and stay in ISSUE. Else if GAP==0, go IDLE. Else load gap counter=GAP-1 and go GAP.
  - GAP: instruction=NOP, issue_valid=0. Counter decrements each cycle; at 0 go IDLE.
- hold: pops are blocked while high. A word already showing in ISSUE is still presented for its one cycle. The GAP counter keeps counting.
- Latency: an accept at edge N with FIFO empty and FSM IDLE gives instruction valid in the cycle after edge N+1 (2 edges).
- busy = (count≠0) || (state≠IDLE).

Optional Feature:
Macro ITYPE_GEN_SHAMT_CHECK_EN.
- Defined: for shift ops, in_imm[11:5]≠0 is treated as illegal. No write occurs and err_illegal pulses.
- Undefined: in_imm[11:5] is silently ignored for shifts.

Decomposition:
- Shared package itype_pkg:
  - op enum (4-bit)
  - OPCODE_OPIMM
  - funct3 constants
  - FUNCT7_SRA
  - NOP_WORD = 32'h0000_0013
  - encode function (op, rd, rs1, imm → 32-bit word)
- Sub-module: itype_sync_fifo (parameterised DEPTH × 32, sync active-low reset, push/pop/count).
- itype_instr_gen instantiates itype_sync_fifo and contains the encoder and the FSM.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, GAP=1 → instruction=32'h0050_0093 with issue_valid=1 for one cycle, then one NOP cycle (32'h0000_0013).
- SRAI rd=2 rs1=1 imm=3 → 32'h4030_D113. ANDI rd=3 rs1=2 imm=12'h0FF → 32'h0FF1_7193.
- Push 5 ops with hold=1 and DEPTH=4 → in_ready drops after the 4th, fifo_count=4, 5th not accepted. Release hold with GAP=0 → 4 consecutive issue_valid cycles in push order, then busy=0.
- in_op=12 handshake → no FIFO change, err_illegal=1 for exactly one cycle. With the macro defined, SLLI imm=12'h021 also pulses err_illegal.
- Assert rst=0 with 3 entries queued and one issuing → next cycle fifo_count=0, issue_valid=0, instruction=32'h0000_0013, busy=0.
- Simultaneous push and pop at count=2 (GAP=0, continuous traffic) → count stays 2, pointers wrap past DEPTH-1, issue order preserved.

Source files
------------

// File: rtl/itype_pkg.sv
// Shared encodings and the OP-IMM encoder for the instruction generator.
// Build option ITYPE_GEN_SHAMT_CHECK_EN: reject shift immediates whose imm[11:5] is nonzero.
package itype_pkg;

    typedef enum logic [3:0] {
        OP_ADDI  = 4'd0,
        OP_SLTI  = 4'd1,
        OP_SLTIU = 4'd2,
        OP_XORI  = 4'd3,
        OP_ORI   = 4'd4,
        OP_ANDI  = 4'd5,
        OP_SLLI  = 4'd6,
        OP_SRLI  = 4'd7,
        OP_SRAI  = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_e;

    localparam logic [3:0]  OP_LAST        = 4'd8;
    localparam logic [6:0]  OPCODE_OPIMM   = 7'b0010011;
    localparam logic [2:0]  F3_ADDI        = 3'b000;
    localparam logic [2:0]  F3_SLTI        = 3'b010;
    localparam logic [2:0]  F3_SLTIU       = 3'b011;
    localparam logic [2:0]  F3_XORI        = 3'b100;
    localparam logic [2:0]  F3_ORI         = 3'b110;
    localparam logic [2:0]  F3_ANDI        = 3'b111;
    localparam logic [2:0]  F3_SLL         = 3'b001;
    localparam logic [2:0]  F3_SRL        = 3'b101;
    localparam logic [6:0]  FUNCT7_LOGICAL = 7'b0000000;
    localparam logic [6:0]  FUNCT7_SRA     = 7'b0100000;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0013;

`ifdef ITYPE_GEN_SHAMT_CHECK_EN
    localparam bit SHAMT_CHECK = 1'b1;
`else
    localparam bit SHAMT_CHECK = 1'b0;
`endif

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
    endfunction

    function automatic logic is_legal(input logic [3:0] op, input logic [11:0] imm);
        return (op <= OP_LAST) && !(SHAMT_CHECK && is_shift(op) && (imm[11:5] != 7'd0));
    endfunction

    function automatic logic [31:0] encode(input logic [3:0]  op,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  rs1,
                                           input logic [11:0] imm);
        logic [2:0]  f3;
        logic [11:0] imm_f;
        f3    = F3_ADDI;
        imm_f = imm;
        case (op)
            OP_SLTI:  f3 = F3_SLTI;
            OP_SLTIU: f3 = F3_SLTIU;
            OP_XORI:  f3 = F3_XORI;
            OP_ORI:   f3 = F3_ORI;
            OP_ANDI:  f3 = F3_ANDI;
            OP_SLLI: begin
                f3    = F3_SLL;
                imm_f = {FUNCT7_LOGICAL, imm[4:0]};
            end
            OP_SRLI: begin
                f3    = F3_SRL;
                imm_f = {FUNCT7_LOGICAL, imm[4:0]};
            end
            OP_SRAI: begin
                f3    = F3_SRL;
                imm_f = {FUNCT7_SRA, imm[4:0]};
            end
            default: f3 = F3_ADDI;
        endcase
        return {imm_f, rs1, f3, rd, OPCODE_OPIMM};
    endfunction

endpackage

// File: rtl/itype_sync_fifo.sv
// Single-clock FIFO with registered occupancy; read data is the head entry (show-ahead).
module itype_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/itype_instr_gen.sv
// Encodes symbolic OP-IMM requests, queues them and issues them to the core with NOP spacing.
// Build option ITYPE_GEN_SHAMT_CHECK_EN (see itype_pkg) tightens shift-immediate legality.
module itype_instr_gen #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [11:0]              in_imm,
    input  logic                     hold,
    output logic [31:0]              instruction,
    output logic                     issue_valid,
    output logic                     err_illegal,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    import itype_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_e         state_q;
    logic [GW-1:0]  gap_q;
    logic [31:0]    instr_q;
    logic           issue_q;
    logic           err_q;

    logic           accept;
    logic           op_ok;
    logic           push;
    logic           pop;
    logic [31:0]    enc_word;
    logic [31:0]    head_word;
    logic [CW-1:0]  count;

    assign op_ok    = is_legal(in_op, in_imm);
    assign enc_word = encode(in_op, in_rd, in_rs1, in_imm);

    // Ready depends only on the registered count, so a full FIFO never accepts even when popping.
    assign in_ready = rst && (count < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && op_ok;

    assign pop = !hold && (count != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_ISSUE) && (GAP == 0)));

    itype_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (enc_word),
        .pop_i     (pop),
        .rd_data_o (head_word),
        .count_o   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            instr_q <= NOP_WORD;
            issue_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= accept && !op_ok;
            instr_q <= NOP_WORD;
            issue_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        instr_q <= head_word;
                        issue_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pop) begin
                        instr_q <= head_word;
                        issue_q <= 1'b1;
                    end else if (GAP == 0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q   <= GAP_LOAD;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    // The spacing counter runs regardless of hold.
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instruction = instr_q;
    assign issue_valid = issue_q;
    assign err_illegal = err_q;
    assign fifo_count  = count;
    assign busy        = (count != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_itype_instr_gen.sv
// Bench for itype_instr_gen: one back-to-back (GAP=0) and one spaced (GAP=1) instance.
module tb_itype_instr_gen;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef ITYPE_GEN_SHAMT_CHECK_EN
    localparam bit SHAMT_CHK = 1'b1;
`else
    localparam bit SHAMT_CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [11:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  v = 2'b00;
    logic [3:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [11:0] imm = '0;
    logic        hold = 1'b0;

    logic [31:0] instr_w [2];
    logic        iv_w   [2];
    logic        err_w  [2];
    logic        rdy_w  [2];
    logic        busy_w [2];
    logic [2:0]  cnt_w  [2];

    logic [31:0] sbq [2][$];
    vec_t        tab [12];
    logic        cur_legal = 1'b0;
    logic [31:0] cur_word = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    itype_instr_gen #(.DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy_w[0]),
        .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_imm(imm), .hold(hold),
        .instruction(instr_w[0]), .issue_valid(iv_w[0]), .err_illegal(err_w[0]),
        .fifo_count(cnt_w[0]), .busy(busy_w[0])
    );

    itype_instr_gen #(.DEPTH(DEPTH), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy_w[1]),
        .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_imm(imm), .hold(hold),
        .instruction(instr_w[1]), .issue_valid(iv_w[1]), .err_illegal(err_w[1]),
        .fifo_count(cnt_w[1]), .busy(busy_w[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int d);
        op        = tab[i].op;
        rd        = tab[i].rd;
        rs1       = tab[i].rs1;
        imm       = tab[i].imm;
        cur_legal = tab[i].legal;
        cur_word  = tab[i].word;
        v         = '0;
        v[d]      = 1'b1;
    endtask

    // One clock: check ready before the edge, then the scoreboard after it.
    task automatic tick();
        logic acc [2];
        logic rst_s;
        #1;
        rst_s = rst;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready[%0d]", d), rdy_w[d], rst && (sbq[d].size() < DEPTH));
            acc[d] = v[d] && rst && (sbq[d].size() < DEPTH);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_s) begin
                sbq[d].delete();
                chk($sformatf("rst_instr[%0d]", d), instr_w[d], NOP);
                chk($sformatf("rst_issue[%0d]", d), iv_w[d], 0);
                chk($sformatf("rst_err[%0d]", d), err_w[d], 0);
                chk($sformatf("rst_count[%0d]", d), cnt_w[d], 0);
                chk($sformatf("rst_busy[%0d]", d), busy_w[d], 0);
            end else begin
                if (iv_w[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("unexpected_issue[%0d]", d), instr_w[d], NOP);
                    end else begin
                        chk($sformatf("issue_word[%0d]", d), instr_w[d], sbq[d].pop_front());
                    end
                end else begin
                    chk($sformatf("nop_word[%0d]", d), instr_w[d], NOP);
                end
                if (acc[d] && cur_legal) sbq[d].push_back(cur_word);
                chk($sformatf("err_illegal[%0d]", d), err_w[d], acc[d] && !cur_legal);
                chk($sformatf("fifo_count[%0d]", d), cnt_w[d], sbq[d].size());
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int seen;
        tab[0]  = '{4'd0,  5'd1,  5'd0,  12'h005, 1'b1,       32'h0050_0093};
        tab[1]  = '{4'd8,  5'd2,  5'd1,  12'h003, 1'b1,       32'h4030_D113};
        tab[2]  = '{4'd5,  5'd3,  5'd2,  12'h0FF, 1'b1,       32'h0FF1_7193};
        tab[3]  = '{4'd1,  5'd4,  5'd3,  12'hFFF, 1'b1,       32'hFFF1_A213};
        tab[4]  = '{4'd2,  5'd5,  5'd4,  12'h800, 1'b1,       32'h8002_3293};
        tab[5]  = '{4'd3,  5'd31, 5'd31, 12'h123, 1'b1,       32'h123F_CF93};
        tab[6]  = '{4'd4,  5'd6,  5'd5,  12'h7FF, 1'b1,       32'h7FF2_E313};
        tab[7]  = '{4'd7,  5'd8,  5'd7,  12'h01F, 1'b1,       32'h01F3_D413};
        tab[8]  = '{4'd6,  5'd1,  5'd1,  12'h021, !SHAMT_CHK, 32'h0010_9093};
        tab[9]  = '{4'd6,  5'd7,  5'd6,  12'hFE1, !SHAMT_CHK, 32'h0013_1393};
        tab[10] = '{4'd12, 5'd9,  5'd9,  12'h001, 1'b0,       32'h0000_0000};
        tab[11] = '{4'd9,  5'd10, 5'd3,  12'h002, 1'b0,       32'h0000_0000};

        // Reset and idle state
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_busy0", busy_w[0], 0);
        chk("idle_busy1", busy_w[1], 0);

        // Encoding table, back-to-back on the GAP=0 instance
        for (int i = 0; i < 12; i++) begin
            set_vec(i, 0);
            tick();
        end
        v = '0;
        repeat (6) tick();
        chk("table_drained_busy", busy_w[0], 0);

        // Latency and one NOP of spacing on the GAP=1 instance
        set_vec(0, 1);
        tick();
        v = '0;
        tick();
        chk("gap1_issue", iv_w[1], 1);
        tick();
        chk("gap1_nop_valid", iv_w[1], 0);
        chk("gap1_busy_in_gap", busy_w[1], 1);
        tick();
        chk("gap1_busy_done", busy_w[1], 0);

        set_vec(1, 1);
        tick();
        set_vec(2, 1);
        tick();
        v = '0;
        chk("gap1_first", iv_w[1], 1);
        tick();
        chk("gap1_spacing", iv_w[1], 0);
        seen = 0;
        for (int k = 0; k < 4 && seen == 0; k++) begin
            tick();
            if (iv_w[1]) seen = 1;
        end
        chk("gap1_second_issued", seen, 1);
        repeat (3) tick();
        chk("gap1_final_busy", busy_w[1], 0);

        // Fill under hold, fifth push refused, then drain back-to-back
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_vec(i, 0);
            tick();
        end
        v = '0;
        #1;
        chk("full_ready", rdy_w[0], 0);
        chk("full_count", cnt_w[0], 4);
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain_issue_%0d", k), iv_w[0], 1);
        end
        tick();
        chk("drain_after_issue", iv_w[0], 0);
        chk("drain_busy", busy_w[0], 0);

        // Illegal op pulses for one cycle and leaves the FIFO alone
        set_vec(10, 0);
        tick();
        v = '0;
        chk("illegal_pulse", err_w[0], 1);
        tick();
        chk("illegal_pulse_end", err_w[0], 0);
        chk("illegal_count", cnt_w[0], 0);

        // Reset while three words are queued and one is issuing
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_vec(i, 0);
            tick();
        end
        v = '0;
        hold = 1'b0;
        tick();
        chk("pre_rst_issue", iv_w[0], 1);
        chk("pre_rst_count", cnt_w[0], 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", busy_w[0], 0);

        // Continuous traffic at count 2: push and pop together, pointers wrap
        hold = 1'b1;
        set_vec(0, 0);
        tick();
        set_vec(1, 0);
        tick();
        hold = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_vec((k + 2) % 8, 0);
            tick();
            chk($sformatf("stream_count_%0d", k), cnt_w[0], 2);
            chk($sformatf("stream_issue_%0d", k), iv_w[0], 1);
        end
        v = '0;
        repeat (5) tick();
        chk("stream_busy", busy_w[0], 0);
        chk("stream_sb_empty", sbq[0].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
